// File: rtl/pipelined_modulo_reducer_if.sv
// pipelined_modulo_reducer_if
//   Handshake and data bundle between the encoder counter and the modulo reducer.
//   slave modport: reducer side. master modport: producer/consumer side.
//   Signals:
//     in_valid, in_ready, encoder_input   : input handshake and count
//     out_valid, out_ready                : output handshake
//     input_mod, input_div                : remainder and quotient
//     mod_offset                          : alignment offset, only present
//                                           with PIPELINED_MODULO_REDUCER_OFFSET_EN
//   Parameters must match those of the attached pipelined_modulo_reducer.
interface pipelined_modulo_reducer_if #(
  parameter int IN_WIDTH = 13,
  parameter int MODULUS  = 1170
);
`ifdef PIPELINED_MODULO_REDUCER_OFFSET_EN
  localparam int SUM_WIDTH = IN_WIDTH + 1;
`else
  localparam int SUM_WIDTH = IN_WIDTH;
`endif
  localparam int OUT_WIDTH = $clog2(MODULUS);
  localparam int STAGES    = SUM_WIDTH - OUT_WIDTH + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  encoder_input;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] input_mod;
  logic [STAGES-1:0]    input_div;
`ifdef PIPELINED_MODULO_REDUCER_OFFSET_EN
  logic [OUT_WIDTH-1:0] mod_offset;
`endif

  modport slave (
`ifdef PIPELINED_MODULO_REDUCER_OFFSET_EN
    input  mod_offset,
`endif
    input  in_valid, encoder_input, out_ready,
    output in_ready, out_valid, input_mod, input_div
  );

  modport master (
`ifdef PIPELINED_MODULO_REDUCER_OFFSET_EN
    output mod_offset,
`endif
    output in_valid, encoder_input, out_ready,
    input  in_ready, out_valid, input_mod, input_div
  );
endinterface

// File: rtl/pipelined_modulo_reducer.sv
// pipelined_modulo_reducer
//   Reduces an unsigned encoder count modulo MODULUS using a pipeline of
//   restoring subtractions, one quotient bit per stage, with valid/ready flow
//   control. Feeds the commutation lookup table.
//   Ports:
//     clk    : system clock
//     reset  : synchronous, active-low reset
//     bus    : pipelined_modulo_reducer_if.slave (handshakes, count, results)
//   Optional feature macro: PIPELINED_MODULO_REDUCER_OFFSET_EN
//     adds bus.mod_offset, added to the count before reduction; the working
//     width grows by one bit and the pipeline by one stage.
//   Latency: STAGES cycles from accepting edge to out_valid.
module pipelined_modulo_reducer #(
  parameter int IN_WIDTH = 13,
  parameter int MODULUS  = 1170
) (
  input logic                        clk,
  input logic                        reset,
  pipelined_modulo_reducer_if.slave  bus
);
`ifdef PIPELINED_MODULO_REDUCER_OFFSET_EN
  localparam int SUM_WIDTH = IN_WIDTH + 1;
`else
  localparam int SUM_WIDTH = IN_WIDTH;
`endif
  localparam int OUT_WIDTH = $clog2(MODULUS);
  localparam int STAGES    = SUM_WIDTH - OUT_WIDTH + 1;

  // One spare bit so the most significant shifted divisor cannot overflow.
  localparam logic [SUM_WIDTH:0] MOD_W = (SUM_WIDTH+1)'(MODULUS);

  // Index 0 holds the sampled input; index k+1 holds the result of stage k.
  logic [STAGES:0]      valid_q;
  logic [SUM_WIDTH:0]   rem_q [0:STAGES];
  logic [SUM_WIDTH:0]   rem_d [0:STAGES];
  logic [STAGES-1:0]    quo_q [0:STAGES];
  logic [STAGES-1:0]    quo_d [0:STAGES];
  logic [SUM_WIDTH-1:0] sum_in;
  logic                 advance;

  assign advance      = !valid_q[STAGES] || bus.out_ready;
  assign bus.in_ready = advance;

`ifdef PIPELINED_MODULO_REDUCER_OFFSET_EN
  assign sum_in = SUM_WIDTH'(bus.encoder_input) + SUM_WIDTH'(bus.mod_offset);
`else
  assign sum_in = bus.encoder_input;
`endif

  // Bubbles carry zero data so an idle output reads as (0, 0).
  assign rem_d[0] = bus.in_valid ? {1'b0, sum_in} : '0;
  assign quo_d[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [SUM_WIDTH:0] DIV_K = MOD_W << (STAGES - 1 - k);
    localparam logic [STAGES-1:0]  QBIT  = STAGES'(1) << (STAGES - 1 - k);
    logic ge;
    // >= so that exact multiples of the divisor reduce to zero.
    assign ge           = rem_q[k] >= DIV_K;
    assign rem_d[k + 1] = ge ? (rem_q[k] - DIV_K) : rem_q[k];
    assign quo_d[k + 1] = ge ? (quo_q[k] | QBIT) : quo_q[k];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i <= STAGES; i++) begin
        rem_q[i] <= '0;
        quo_q[i] <= '0;
      end
    end else if (advance) begin
      valid_q <= {valid_q[STAGES-1:0], bus.in_valid};
      for (int i = 0; i <= STAGES; i++) begin
        rem_q[i] <= rem_d[i];
        quo_q[i] <= quo_d[i];
      end
    end
  end

  assign bus.out_valid = valid_q[STAGES];
  assign bus.input_mod = rem_q[STAGES][OUT_WIDTH-1:0];
  assign bus.input_div = quo_q[STAGES];
endmodule

// File: doc/pipelined_modulo_reducer.md
Name: pipelined_modulo_reducer

Overview:
- Reduces an unsigned encoder count modulo a compile-time MODULUS. Returns remainder (electrical angle index) and quotient (pole-pair or sector index).
- Generalised successor to the fixed 13-bit / 1170 reducer:
  - modulus and width are parametrised;
  - remainder is guaranteed in [0, MODULUS-1];
  - pipelined restoring subtraction with valid/ready handshake.
- Sits between the encoder counter and the commutation lookup table in the BLDC velocity controller.

Parameters:
- IN_WIDTH, 13: width of encoder_input.
- MODULUS, 1170: divisor; 2 <= MODULUS < 2^IN_WIDTH.
- OUT_WIDTH, $clog2(MODULUS): remainder width (derived; do not override).
- STAGES, IN_WIDTH - $clog2(MODULUS) + 1: pipeline depth and quotient width (derived).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  encoder_input is valid this cycle
- in_ready  out  1  block accepts input this cycle
- encoder_input  in  IN_WIDTH  unsigned count
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- input_mod  out  OUT_WIDTH  encoder_input mod MODULUS
- input_div  out  STAGES  floor(encoder_input / MODULUS)

Behaviour:
- Reset: reset=0 at a rising clk clears every stage valid bit and every data register. Outputs then read out_valid=0, input_mod=0, input_div=0. in_ready is 1 while reset is deasserted and the pipe is empty.
- Reset asserted mid-operation discards all in-flight samples. No result for them is ever produced.
- Datapath:
  - Stage k (k = 0..STAGES-1) holds remainder r_k and partial quotient q_k.
  - Let D_k = MODULUS << (STAGES-1-k).
  - If r_k >= D_k, then r_{k+1} = r_k - D_k and quotient bit (STAGES-1-k) = 1. Otherwise pass r_k unchanged, bit = 0.
  - Compare and subtract use IN_WIDTH+1 bits so that D_0 does not overflow.
  - The comparison is >= (not >). An input equal to any multiple of MODULUS yields remainder 0.
- Latency: exactly STAGES cycles from handshake acceptance (in_valid & in_ready at a rising edge) to out_valid, when out_ready is held 1. Throughput is one sample per cycle.
- Flow control:
  - advance = !out_valid | out_ready.
  - in_ready = advance.
  - When advance=0, all stages hold their contents. Outputs stay stable while out_valid=1 and out_ready=0.
  - A stage whose valid bit is 0 still advances. Bubbles propagate and do not block.
- Simultaneous events: on the same edge the output handshake completes and a new input is accepted. The pipe shifts by one; no sample is lost or duplicated.
- Results leave in acceptance order.
- encoder_input is sampled only on the accepting edge. Changes while in_ready=0 are ignored.
- Boundary results (default parameters):
  - 0 -> (0, 0)
  - 1169 -> (1169, 0)
  - 1170 -> (0, 1)
  - 8191 -> (1, 7)

Optional Feature:
- Macro: PIPELINED_MODULO_REDUCER_OFFSET_EN
- With the macro:
  - Adds input port mod_offset (in, OUT_WIDTH), the commutation alignment offset. It must be < MODULUS; results are undefined otherwise.
  - mod_offset is sampled with encoder_input on acceptance.
  - Result = (encoder_input + mod_offset) mod MODULUS, and input_div = floor((encoder_input + mod_offset) / MODULUS).
  - The derived width becomes IN_WIDTH+1 throughout, so STAGES grows by 1 and latency grows by one cycle accordingly.
- Without the macro: the port does not exist, and behaviour is exactly as above.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, input_mod=0, input_div=0. After release, in_ready=1 and no spurious out_valid.
- Boundaries, streamed back-to-back with out_ready=1: inputs 0, 1169, 1170, 1171, 2340, 7020, 7021, 8191 -> results (0,0), (1169,0), (0,1), (1,1), (0,2), (0,6), (1,6), (1,7), each exactly 3 cycles after acceptance, in order.
- Backpressure: stream 4 values, hold out_ready=0 for 5 cycles once out_valid=1 -> in_ready=0, input_mod/input_div stable, no loss. After release, the remaining results arrive on consecutive cycles.
- Reset mid-flight: accept 1170 and 5000, then assert reset on the next edge -> neither result ever appears. A post-reset input of 3000 yields (660, 2).
- Exhaustive sweep: every encoder_input 0..8191 with random in_valid/out_ready -> matches a reference model (x % 1170, x / 1170) exactly, with count in == count out.
- Offset (macro defined): encoder_input=1100, mod_offset=100 -> (30, 1), with latency 4 cycles. encoder_input=8191, mod_offset=1169 -> (0, 8).
